// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache for the MEM stage.
// Two-word lines, refilled and evicted over a 64-bit backing-RAM port.
module dcache_wb #(
    parameter int LINES = 8
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] Addr,
    input  logic [31:0] Data_in,
    input  logic [3:0]  Write_Byte_en,
    input  logic        Read_en,
    output logic [31:0] Data_out,
    output logic        Hit,
    output logic        Stall,
    output logic        Mem_req,
    output logic        Mem_we,
    output logic [31:0] Mem_addr,
    output logic [63:0] Mem_wdata,
    input  logic [63:0] Mem_rdata,
    input  logic        Mem_ack
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 29 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0] tag_q [LINES];
    logic [63:0]      data_q [LINES];
    logic [TAG_W-1:0] tag_d;
    logic [63:0]      data_d;
    logic             line_we;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag_in;
    logic             wsel;
    logic             access;
    logic             hit;
    logic             store_hit;
    logic [TAG_W-1:0] cur_tag;
    logic [63:0]      cur_line;
    logic [31:0]      cur_word;
    logic [31:0]      merged;
    logic             unused_addr;

    assign idx         = Addr[2+IDX_W:3];
    assign tag_in      = Addr[31:3+IDX_W];
    assign wsel        = Addr[2];
    assign unused_addr = ^Addr[1:0];

    always_comb begin
        access   = Read_en | (|Write_Byte_en);
        cur_tag  = tag_q[idx];
        cur_line = data_q[idx];
        cur_word = wsel ? cur_line[63:32] : cur_line[31:0];
        hit      = access & valid_q[idx] & (cur_tag == tag_in);
        store_hit = (state_q == S_IDLE) & hit & (|Write_Byte_en);
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = Write_Byte_en[b] ? Data_in[8*b +: 8]
                                                : cur_word[8*b +: 8];
        end
        Hit      = hit;
        Data_out = hit ? cur_word : 32'd0;
        Stall    = (state_q != S_IDLE) | (access & ~hit);
    end

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate them
    always_ff @(posedge Clk) begin
        if (line_we) begin
            tag_q[idx]  <= tag_d;
            data_q[idx] <= data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (access && !hit) begin
                    if (valid_q[idx] && dirty_q[idx]) state_d = S_WB;
                    else                              state_d = S_FILL;
                end
            end
            S_WB:    if (Mem_ack) state_d = S_FILL;
            S_FILL:  if (Mem_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Line-state and array updates
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        line_we = 1'b0;
        tag_d   = cur_tag;
        data_d  = cur_line;
        case (state_q)
            S_IDLE: begin
                if (store_hit) begin
                    dirty_d[idx] = 1'b1;
                    line_we      = 1'b1;
                    data_d = wsel ? {merged, cur_line[31:0]}
                                  : {cur_line[63:32], merged};
                end
            end
            S_WB: begin
                if (Mem_ack) dirty_d[idx] = 1'b0;
            end
            S_FILL: begin
                if (Mem_ack) begin
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    tag_d        = tag_in;
                    data_d       = Mem_rdata;
                    line_we      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Memory-port outputs, decoded from registered state
    always_comb begin
        Mem_req   = 1'b0;
        Mem_we    = 1'b0;
        Mem_addr  = 32'd0;
        Mem_wdata = 64'd0;
        case (state_q)
            S_WB: begin
                Mem_req   = 1'b1;
                Mem_we    = 1'b1;
                Mem_addr  = {cur_tag, idx, 3'b000};
                Mem_wdata = cur_line;
            end
            S_FILL: begin
                Mem_req  = 1'b1;
                Mem_addr = {tag_in, idx, 3'b000};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed-vector bench for dcache_wb: fills, write-back,
// write-allocate, delayed acks and reset during a fill.
module tb_dcache_wb;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] Addr;
    logic [31:0] Data_in;
    logic [3:0]  Write_Byte_en;
    logic        Read_en;
    logic [31:0] Data_out;
    logic        Hit;
    logic        Stall;
    logic        Mem_req;
    logic        Mem_we;
    logic [31:0] Mem_addr;
    logic [63:0] Mem_wdata;
    logic [63:0] Mem_rdata;
    logic        Mem_ack;

    int total;
    int bad;

    dcache_wb #(.LINES(8)) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Addr          (Addr),
        .Data_in       (Data_in),
        .Write_Byte_en (Write_Byte_en),
        .Read_en       (Read_en),
        .Data_out      (Data_out),
        .Hit           (Hit),
        .Stall         (Stall),
        .Mem_req       (Mem_req),
        .Mem_we        (Mem_we),
        .Mem_addr      (Mem_addr),
        .Mem_wdata     (Mem_wdata),
        .Mem_rdata     (Mem_rdata),
        .Mem_ack       (Mem_ack)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a);
        Addr          = a;
        Read_en       = 1'b1;
        Write_Byte_en = 4'b0000;
        #1;
    endtask

    task automatic ack_step(input logic [63:0] rd);
        Mem_rdata = rd;
        Mem_ack   = 1'b1;
        step();
        Mem_ack   = 1'b0;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Rst_n = 1'b0;
        Addr = '0; Data_in = '0; Write_Byte_en = '0; Read_en = 1'b0;
        Mem_rdata = '0; Mem_ack = 1'b0;
        step();
        step();
        chk("rst_hit",   Hit,      0);
        chk("rst_stall", Stall,    0);
        chk("rst_req",   Mem_req,  0);
        chk("rst_dout",  Data_out, 0);
        Rst_n = 1'b1;
        step();

        // Clean miss on 0x40, then fill
        load(32'h40);
        chk("m40_stall", Stall,   1);
        chk("m40_hit",   Hit,     0);
        chk("m40_req0",  Mem_req, 0);
        step();
        chk("f40_req",   Mem_req,  1);
        chk("f40_we",    Mem_we,   0);
        chk("f40_addr",  Mem_addr, 32'h40);
        chk("f40_stall", Stall,    1);
        ack_step(64'h22222222_11111111);
        chk("h40_hit",   Hit,      1);
        chk("h40_stall", Stall,    0);
        chk("h40_dout",  Data_out, 32'h11111111);
        load(32'h44);
        chk("h44_dout",  Data_out, 32'h22222222);
        chk("h44_stall", Stall,    0);

        // Byte store hit
        Addr = 32'h40; Read_en = 1'b0;
        Data_in = 32'h0000AB00; Write_Byte_en = 4'b0010;
        #1;
        chk("st40_hit",   Hit,   1);
        chk("st40_stall", Stall, 0);
        step();
        load(32'h40);
        chk("ld40_merge", Data_out, 32'h1111AB11);

        // Dirty conflict miss on 0x80
        load(32'h80);
        chk("m80_stall", Stall,   1);
        chk("m80_req0",  Mem_req, 0);
        step();
        chk("wb_req",   Mem_req,   1);
        chk("wb_we",    Mem_we,    1);
        chk("wb_addr",  Mem_addr,  32'h40);
        chk("wb_data",  Mem_wdata, 64'h22222222_1111AB11);
        chk("wb_stall", Stall,     1);
        ack_step(64'hDEAD_DEAD_DEAD_DEAD);
        chk("f80_req",   Mem_req,  1);
        chk("f80_we",    Mem_we,   0);
        chk("f80_addr",  Mem_addr, 32'h80);
        chk("f80_stall", Stall,    1);
        ack_step(64'h44444444_33333333);
        chk("h80_hit",   Hit,      1);
        chk("h80_stall", Stall,    0);
        chk("h80_dout",  Data_out, 32'h33333333);
        load(32'h40);
        chk("evict40_hit", Hit, 0);
        Read_en = 1'b0;
        step();

        // Store miss with write-allocate and a slow ack
        Addr = 32'h100; Data_in = 32'hDEADBEEF;
        Write_Byte_en = 4'b1111; Read_en = 1'b0;
        #1;
        chk("m100_stall", Stall, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("wait_req",   Mem_req,  1);
            chk("wait_addr",  Mem_addr, 32'h100);
            chk("wait_we",    Mem_we,   0);
            chk("wait_stall", Stall,    1);
            step();
        end
        ack_step(64'h66666666_55555555);
        chk("h100_hit",   Hit,   1);
        chk("h100_stall", Stall, 0);
        step();
        load(32'h100);
        chk("ld100_dout", Data_out, 32'hDEADBEEF);
        load(32'h104);
        chk("ld104_dout", Data_out, 32'h66666666);

        // Spurious ack while idle
        Read_en = 1'b0;
        ack_step(64'hFFFFFFFF_FFFFFFFF);
        chk("spur_req", Mem_req, 0);
        load(32'h100);
        chk("spur_hit",  Hit,      1);
        chk("spur_dout", Data_out, 32'hDEADBEEF);
        chk("spur_stall", Stall,   0);

        // Reset in the middle of a fill
        load(32'h208);
        chk("m208_stall", Stall, 1);
        step();
        chk("f208_req", Mem_req, 1);
        Rst_n = 1'b0;
        #1;
        chk("rstf_req",  Mem_req,  0);
        chk("rstf_addr", Mem_addr, 0);
        chk("rstf_hit",  Hit,      0);
        Mem_rdata = 64'h12345678_9ABCDEF0;
        Mem_ack   = 1'b1;
        step();
        Mem_ack = 1'b0;
        Rst_n   = 1'b1;
        #1;
        chk("post_rst_hit",   Hit,     0);
        chk("post_rst_stall", Stall,   1);
        chk("post_rst_req",   Mem_req, 0);
        load(32'h100);
        chk("post_rst_100", Hit, 0);
        Read_en = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/dcache_wb.md
# dcache_wb

Direct-mapped, write-back, write-allocate data cache placed in the MEM stage between the EX/MEM register and the MEM/WB register. It replaces the flat data memory. It accepts the lane-shifted store data and the 4-bit byte write enables produced by the condition check, and returns the 32-bit load word to the memory shift unit. Misses are serviced over a 64-bit line interface to backing RAM. While a miss is serviced, a Stall output freezes the pipeline.

## Interface
- LINES, 8: number of cache lines; power of two, ≥2; IDX_W = log2(LINES)
- Line size is fixed at 2 words (64 bits); tag = Addr[31:3+IDX_W], index = Addr[2+IDX_W:3], word select = Addr[2]
- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Addr  in  32  byte address from EX/MEM; Addr[1:0] ignored
- Data_in  in  32  store data, already lane-shifted
- Write_Byte_en  in  4  per-byte write enable; nonzero means store
- Read_en  in  1  load request
- Data_out  out  32  load word (combinational)
- Hit  out  1  access present and tag/valid match (combinational)
- Stall  out  1  hold IF/ID/EX/MEM stages; MEM/WB takes a bubble
- Mem_req  out  1  backing-RAM request, held until ack
- Mem_we  out  1  1 = line write-back, 0 = line fill
- Mem_addr  out  32  line-aligned address, [2:0]=0
- Mem_wdata  out  64  victim line, word 0 in [31:0]
- Mem_rdata  in  64  fill line, word 0 in [31:0]
- Mem_ack  in  1  single-cycle completion pulse

## Operation
- access = Read_en | (|Write_Byte_en); hit = access & valid[idx] & (tag[idx]==Addr tag).
- Per-line state: valid, dirty, tag, 64-bit data.
- FSM states: IDLE, WB, FILL.
- IDLE, read hit: Data_out = selected word; no state change.
- IDLE, write hit: on the clock edge, merge enabled bytes into the selected word and set dirty. Read_en is irrelevant when Write_Byte_en is nonzero.
- IDLE, miss: if the line is valid and dirty, go to WB; otherwise go to FILL.
- WB: Mem_req=1, Mem_we=1, Mem_addr={victim tag, idx, 3'b0}, Mem_wdata=victim line. On Mem_ack, clear dirty[idx] and go to FILL.
- FILL: Mem_req=1, Mem_we=0, Mem_addr={Addr tag, idx, 3'b0}. On Mem_ack, load Mem_rdata, set tag, valid=1, dirty=0, and go to IDLE.
- After FILL returns to IDLE, the held access re-evaluates and hits. A store then merges in that cycle (write-allocate).
- Stall = (state != IDLE) | (access & ~hit).
- Data_out = 0 whenever hit=0.
- Mem_req=0, Mem_we=0, Mem_addr=0, Mem_wdata=0 in IDLE.
- Mem_ack is ignored in IDLE.
- Addr, Data_in, Write_Byte_en and Read_en must stay stable while Stall=1. This is guaranteed by the pipeline. The cache latches nothing from them except through FSM decisions.

## Timing
- Hit: zero added latency. Load data is valid in the same cycle. Store commits at the next rising edge.
- Clean miss detected in cycle T: Stall=1 in T. FILL starts at T+1. With ack in cycle T+k (k ≥ 1), IDLE resumes at T+k+1 with Hit=1 and Stall=0. Minimum penalty is 2 stall cycles.
- Dirty miss: WB ack at cycle T+a, then FILL ack at cycle T+a+b, then hit at cycle T+a+b+1. Minimum penalty is 3 stall cycles.
- Mem_req, Mem_we, Mem_addr and Mem_wdata are decoded from the registered state and stay stable across wait cycles.
- Reset (Rst_n=0, asynchronous):
  - all valid and dirty bits cleared, state = IDLE
  - Mem_req, Mem_we, Mem_addr, Mem_wdata = 0
  - Hit, Data_out = 0; Stall follows the access input
  - An in-flight WB or FILL is abandoned with no line update.
  - A Mem_ack arriving during or after reset is ignored.
- Data array contents are not reset.

## Test plan
- After reset, load from Addr=0x40: Stall=1, FILL with Mem_addr=0x40. Ack with Mem_rdata=0x22222222_11111111 → next cycle Hit=1, Stall=0, Data_out=0x11111111. Load from 0x44 → Data_out=0x22222222 with no stall.
- Store Data_in=0x0000AB00 with Write_Byte_en=4'b0010 to cached 0x40 → reload 0x40 returns 0x1111AB11 and the line is dirty.
- Load from 0x80 (LINES=8, same index as 0x40, different tag) while the line is dirty:
  - WB with Mem_addr=0x40, Mem_wdata=0x22222222_1111AB11, Mem_we=1
  - after ack, FILL with Mem_addr=0x80
  - after ack, hit
  - minimum 3 stall cycles
- Store miss to 0x100 with byte enable 4'b1111 and Data_in=0xDEADBEEF → fill, then the word merges at the hit cycle. A later load of 0x100 returns 0xDEADBEEF.
- Delay Mem_ack by 5 cycles → Mem_req and Mem_addr stay constant and Stall stays high throughout. A spurious Mem_ack in IDLE causes no state change.
- Assert Rst_n low during FILL → Mem_req drops immediately. After release, a load to the same address misses again.
